// File: rtl/fir_mac_sequencer.sv
// ============================================================================
//  Module   : fir_mac_sequencer
//  Brief    : Tap/channel control sequencer for a time-multiplexed FIR MAC.
//             Optional macro FIRSEQ_DEBUG_COUNT_EN adds an 8-bit cycle counter.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fir_mac_sequencer #(
    parameter int NTAPS  = 16,
    parameter int CSEL_W = 4,
    parameter int NCH    = 2,
    parameter int CH_W   = 1
) (
    input  logic              Clock,
    input  logic              GlobalReset,
    input  logic              srdyi,
    output logic [CSEL_W-1:0] coeff_sel,
    output logic [CH_W-1:0]   ch_sel,
    output logic              sum_rst,
    output logic              sum_en,
    output logic              srdyo,
    output logic [CH_W-1:0]   srdyo_ch,
    output logic              busy,
    output logic              overrun
`ifdef FIRSEQ_DEBUG_COUNT_EN
    ,
    output logic [7:0]        count
`endif
);

    localparam logic [0:0]        c_st_idle  = 1'b0;
    localparam logic [0:0]        c_st_run   = 1'b1;
    localparam logic [CSEL_W-1:0] c_last_tap = CSEL_W'(NTAPS - 1);
    localparam logic [CH_W-1:0]   c_last_ch  = CH_W'(NCH - 1);

    logic [0:0]        r_state;
    logic [CSEL_W-1:0] r_tap;
    logic [CH_W-1:0]   r_ch;
    logic              r_pending;
    logic              r_overrun;
    logic              r_sum_rst;
    logic              r_srdyo;
    logic [CH_W-1:0]   r_srdyo_ch;

    logic              w_run;
    logic              w_tap_wrap;
    logic              w_last;
    logic              w_start;
    logic              w_run_nxt;
    logic [CSEL_W-1:0] w_tap_nxt;
    logic [CH_W-1:0]   w_ch_nxt;

    always_comb begin
        w_run      = (r_state == c_st_run);
        w_tap_wrap = w_run && (r_tap == c_last_tap);
        w_last     = w_tap_wrap && (r_ch == c_last_ch);
        // A frame begins from IDLE or seamlessly from the last cycle of the previous one
        w_start    = ((r_state == c_st_idle) && srdyi) || (w_last && (r_pending || srdyi));
        w_run_nxt  = w_start || (w_run && !w_last);
        w_tap_nxt  = r_tap + CSEL_W'(1);
        w_ch_nxt   = r_ch;
        if (w_start || w_tap_wrap) begin
            w_tap_nxt = '0;
        end
        if (w_start) begin
            w_ch_nxt = '0;
        end else if (w_tap_wrap) begin
            w_ch_nxt = r_ch + CH_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (GlobalReset) begin
            r_state    <= c_st_idle;
            r_tap      <= '0;
            r_ch       <= '0;
            r_pending  <= 1'b0;
            r_overrun  <= 1'b0;
            r_sum_rst  <= 1'b0;
            r_srdyo    <= 1'b0;
            r_srdyo_ch <= '0;
        end else begin
            r_state    <= w_run_nxt ? c_st_run : c_st_idle;
            r_tap      <= w_run_nxt ? w_tap_nxt : '0;
            r_ch       <= w_run_nxt ? w_ch_nxt : '0;
            r_sum_rst  <= w_run_nxt && (w_tap_nxt == '0);
            r_srdyo    <= w_tap_wrap;
            r_srdyo_ch <= w_tap_wrap ? r_ch : '0;
            if (w_last) begin
                r_pending <= r_pending && srdyi;
            end else if (w_run && srdyi) begin
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                end
            end
        end
    end

    // Tap and channel registers idle at zero, so they drive the selects directly
    assign coeff_sel = r_tap;
    assign ch_sel    = r_ch;
    assign sum_rst   = r_sum_rst;
    assign sum_en    = r_state;
    assign busy      = r_state;
    assign srdyo     = r_srdyo;
    assign srdyo_ch  = r_srdyo_ch;
    assign overrun   = r_overrun;

`ifdef FIRSEQ_DEBUG_COUNT_EN
    logic [7:0] r_count;

    always_ff @(posedge Clock) begin
        if (GlobalReset || w_start) begin
            r_count <= 8'd0;
        end else if (r_count != 8'hFF) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign count = r_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
// ============================================================================
//  Module   : tb_fir_mac_sequencer
//  Brief    : Scoreboard bench for fir_mac_sequencer (default and 5x3 builds).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fir_mac_sequencer;

    localparam int c_inf = 1 << 30;

    typedef struct {
        int         cyc;
        logic [3:0] cs;
        logic [1:0] ch;
        logic       rst;
        logic       run;
        logic       ov;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [1:0] ch;
    } out_t;

    logic       Clock = 1'b0;
    logic       GlobalReset = 1'b1;
    logic       srdyi = 1'b0;
    logic       srdyi6 = 1'b0;

    logic [3:0] coeff_sel;
    logic [0:0] ch_sel;
    logic       sum_rst, sum_en, srdyo, busy, overrun;
    logic [0:0] srdyo_ch;

    logic [2:0] coeff_sel6;
    logic [1:0] ch_sel6;
    logic       sum_rst6, sum_en6, srdyo6, busy6, overrun6;
    logic [1:0] srdyo_ch6;
`ifdef FIRSEQ_DEBUG_COUNT_EN
    logic [7:0] count_a;
    logic [7:0] count6;
`endif

    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];
    vec_t vq6[$];
    out_t oq[$];
    out_t oq6[$];

    fir_mac_sequencer #(.NTAPS(16), .CSEL_W(4), .NCH(2), .CH_W(1)) u_dut (
        .Clock(Clock), .GlobalReset(GlobalReset), .srdyi(srdyi),
        .coeff_sel(coeff_sel), .ch_sel(ch_sel), .sum_rst(sum_rst), .sum_en(sum_en),
        .srdyo(srdyo), .srdyo_ch(srdyo_ch), .busy(busy), .overrun(overrun)
`ifdef FIRSEQ_DEBUG_COUNT_EN
        , .count(count_a)
`endif
    );

    fir_mac_sequencer #(.NTAPS(5), .CSEL_W(3), .NCH(3), .CH_W(2)) u_dut6 (
        .Clock(Clock), .GlobalReset(GlobalReset), .srdyi(srdyi6),
        .coeff_sel(coeff_sel6), .ch_sel(ch_sel6), .sum_rst(sum_rst6), .sum_en(sum_en6),
        .srdyo(srdyo6), .srdyo_ch(srdyo_ch6), .busy(busy6), .overrun(overrun6)
`ifdef FIRSEQ_DEBUG_COUNT_EN
        , .count(count6)
`endif
    );

    always #5 Clock = ~Clock;

    // After edge number e-1 the visible cycle is e
    always @(posedge Clock) edge_n <= edge_n + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, edge_n, act, exp);
        end
    endfunction

    function automatic void monitor(input int sel, input logic [3:0] cs, input logic [1:0] ch,
                                    input logic rst, input logic en, input logic bsy,
                                    input logic ov, input logic so, input logic [1:0] soch);
        string pfx;
        vec_t  v;
        out_t  o;
        int    vis;
        vis = edge_n;
        pfx = (sel == 0) ? "a_" : "b_";
        while ((sel == 0) ? (vq.size() > 0 && vq[0].cyc <= vis)
                          : (vq6.size() > 0 && vq6[0].cyc <= vis)) begin
            if (sel == 0) v = vq.pop_front();
            else          v = vq6.pop_front();
            if (v.cyc < vis) begin
                chk({pfx, "vec_skipped"}, vis, v.cyc);
            end else begin
                chk({pfx, "coeff_sel"}, cs, v.cs);
                chk({pfx, "ch_sel"}, ch, v.ch);
                chk({pfx, "sum_rst"}, rst, v.rst);
                chk({pfx, "sum_en"}, en, v.run);
                chk({pfx, "busy"}, bsy, v.run);
                chk({pfx, "overrun"}, ov, v.ov);
            end
        end
        if (so) begin
            if ((sel == 0 && oq.size() == 0) || (sel != 0 && oq6.size() == 0)) begin
                chk({pfx, "srdyo_unexpected"}, 1, 0);
            end else begin
                if (sel == 0) o = oq.pop_front();
                else          o = oq6.pop_front();
                chk({pfx, "srdyo_cycle"}, vis, o.cyc);
                chk({pfx, "srdyo_ch"}, soch, o.ch);
            end
        end else begin
            chk({pfx, "srdyo_ch_idle"}, soch, 0);
            if (sel == 0 && oq.size() > 0 && oq[0].cyc < vis) begin
                chk({pfx, "srdyo_missing"}, vis, oq[0].cyc);
                void'(oq.pop_front());
            end
            if (sel != 0 && oq6.size() > 0 && oq6[0].cyc < vis) begin
                chk({pfx, "srdyo_missing"}, vis, oq6[0].cyc);
                void'(oq6.pop_front());
            end
        end
    endfunction

    always @(negedge Clock) begin
        if (edge_n >= 1) begin
            monitor(0, coeff_sel, {1'b0, ch_sel}, sum_rst, sum_en, busy, overrun,
                    srdyo, {1'b0, srdyo_ch});
            monitor(1, {1'b0, coeff_sel6}, ch_sel6, sum_rst6, sum_en6, busy6, overrun6,
                    srdyo6, srdyo_ch6);
        end
    end

    // Frame started by the edge at absolute index b: first nv cycles of expectations
    task automatic push_frame(input int sel, input int b, input int nt, input int nc,
                              input int nv, input int ov_from);
        for (int n = 0; n < nv; n++) begin
            vec_t v;
            v.cyc = b + 1 + n;
            v.cs  = 4'(n % nt);
            v.ch  = 2'(n / nt);
            v.rst = (n % nt == 0);
            v.run = 1'b1;
            v.ov  = (v.cyc >= ov_from);
            if (sel == 0) vq.push_back(v);
            else          vq6.push_back(v);
        end
        for (int c = 0; c < nc; c++) begin
            if ((c + 1) * nt <= nv) begin
                out_t o;
                o.cyc = b + 1 + (c + 1) * nt;
                o.ch  = 2'(c);
                if (sel == 0) oq.push_back(o);
                else          oq6.push_back(o);
            end
        end
    endtask

    task automatic push_idle(input int sel, input int c0, input int c1, input logic ov);
        for (int c = c0; c <= c1; c++) begin
            vec_t v;
            v.cyc = c; v.cs = '0; v.ch = '0; v.rst = 1'b0; v.run = 1'b0; v.ov = ov;
            if (sel == 0) vq.push_back(v);
            else          vq6.push_back(v);
        end
    endtask

    task automatic do_reset(output int b);
        @(negedge Clock);
        GlobalReset = 1'b1;
        repeat (3) @(negedge Clock);
        GlobalReset = 1'b0;
        b = edge_n;
    endtask

    task automatic pulse_at(input int e);
        while (edge_n < e) @(negedge Clock);
        srdyi = 1'b1;
        @(negedge Clock);
        srdyi = 1'b0;
    endtask

    task automatic wait_until(input int e);
        while (edge_n < e) @(negedge Clock);
    endtask

    initial begin
        int b;
        repeat (2) @(negedge Clock);

        // Reset held with srdyi high: everything stays at zero
        srdyi = 1'b1;
        b = edge_n;
        push_idle(0, b + 1, b + 100, 1'b0);
        push_idle(1, b + 1, b + 100, 1'b0);
        repeat (100) @(negedge Clock);
        srdyi = 1'b0;
        GlobalReset = 1'b0;

        // Single frame
        do_reset(b);
        push_frame(0, b, 16, 2, 32, c_inf);
        push_idle(0, b + 33, b + 36, 1'b0);
        pulse_at(b);
        wait_until(b + 40);

        // Back-to-back frames, second request on the last cycle
        do_reset(b);
        push_frame(0, b, 16, 2, 32, c_inf);
        push_frame(0, b + 32, 16, 2, 32, c_inf);
        push_idle(0, b + 65, b + 68, 1'b0);
        pulse_at(b);
        pulse_at(b + 32);
        wait_until(b + 72);

        // One buffered, one dropped request
        do_reset(b);
        push_frame(0, b, 16, 2, 32, b + 10);
        push_frame(0, b + 32, 16, 2, 32, b + 10);
        push_idle(0, b + 65, b + 70, 1'b1);
        pulse_at(b);
        pulse_at(b + 5);
        pulse_at(b + 9);
        wait_until(b + 72);

        // Reset mid-frame with a simultaneous request
        do_reset(b);
        push_frame(0, b, 16, 2, 8, c_inf);
        push_idle(0, b + 9, b + 40, 1'b0);
        pulse_at(b);
        wait_until(b + 8);
        GlobalReset = 1'b1;
        srdyi = 1'b1;
        @(negedge Clock);
        GlobalReset = 1'b0;
        srdyi = 1'b0;
        wait_until(b + 42);

        // Five taps, three channels
        do_reset(b);
        push_frame(1, b, 5, 3, 15, c_inf);
        push_idle(1, b + 16, b + 20, 1'b0);
        while (edge_n < b) @(negedge Clock);
        srdyi6 = 1'b1;
        @(negedge Clock);
        srdyi6 = 1'b0;
`ifdef FIRSEQ_DEBUG_COUNT_EN
        wait_until(b + 17);
        chk("b_count", count6, 16);
`endif
        wait_until(b + 24);

        chk("a_vec_left", vq.size(), 0);
        chk("a_srdyo_left", oq.size(), 0);
        chk("b_vec_left", vq6.size(), 0);
        chk("b_srdyo_left", oq6.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
